instr_loader: RTL and testbench

Writer side of the instruction memory. It accepts a framed byte stream from a host link, assembles big-endian 32-bit instruction words, and drives the write port of the instruction RAM. It holds the processor in stall for the whole load. The processor fetch path stays the read side of the same memory.

---
 rtl/isa_pkg.sv | 28 ++
 rtl/byte_word_packer.sv | 46 ++++
 rtl/instr_loader.sv | 153 +++++++++++++++
 tb/tb_instr_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared constants and types for the instruction-memory loader.
package isa_pkg;

    localparam int unsigned N              = 32;
    localparam int unsigned DEPTH          = 32;
    localparam int unsigned AW             = $clog2(DEPTH);
    localparam int unsigned BYTES_PER_WORD = N / 8;

    // Loader control states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_H_BASE  = 3'd1,
        S_H_CNT   = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } loader_state_e;

    // Frame field order on the host link: BASE, COUNT, payload, CSUM
    typedef enum logic [1:0] {
        FLD_BASE    = 2'd0,
        FLD_COUNT   = 2'd1,
        FLD_PAYLOAD = 2'd2,
        FLD_CSUM    = 2'd3
    } frame_field_e;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles big-endian W-bit words from a byte stream (first byte is MSB).
module byte_word_packer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [7:0]   i_byte,
    output logic [W-1:0] o_word_next_c,
    output logic         o_word_done_c,
    output logic         o_word_ready
);

    localparam int unsigned BYTES = W / 8;
    localparam int unsigned CW    = $clog2(BYTES);

    logic [W-1:0]  r_word;
    logic [CW-1:0] r_cnt;
    logic          r_word_ready;

    // Word as it will look once the current byte is shifted in
    assign o_word_next_c = {r_word[W-9:0], i_byte};
    assign o_word_done_c = i_en && (r_cnt == CW'(BYTES - 1));
    assign o_word_ready  = r_word_ready;

    // Shift register, byte counter and one-cycle word_ready pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word       <= '0;
            r_cnt        <= '0;
            r_word_ready <= 1'b0;
        end else if (i_clr) begin
            r_word       <= '0;
            r_cnt        <= '0;
            r_word_ready <= 1'b0;
        end else begin
            r_word_ready <= o_word_done_c;
            if (i_en) begin
                r_word <= o_word_next_c;
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Writer side of the instruction RAM: framed byte stream -> word writes.
module instr_loader
    import isa_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          cpu_stall,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words_loaded
);

    loader_state_e r_state;
    logic          r_byte_ready;
    logic          r_cpu_stall;
    logic          r_done;
    logic          r_error;
    logic [AW:0]   r_words;
    logic [AW-1:0] r_mem_addr;
    logic [N-1:0]  r_mem_wdata;
    logic [7:0]    r_base_byte;
    logic [AW:0]   r_count;
    logic [7:0]    r_csum;

    logic          w_xfer;
    logic          w_start_acc;
    logic          w_pk_en;
    logic [N-1:0]  w_word_next;
    logic          w_word_done;
    logic          w_word_ready;
    logic [AW+1:0] w_span;
    logic          w_cnt_bad;
    logic          w_last_word;

    assign w_xfer      = byte_valid && r_byte_ready;
    assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_pk_en     = w_xfer && (r_state == S_PAYLOAD);

    // Header range check: base must be in range and the span must fit memory
    assign w_span    = (AW+2)'(r_base_byte[AW-1:0]) + (AW+2)'(byte_in[AW:0]);
    assign w_cnt_bad = (byte_in == 8'd0) || (byte_in > 8'(DEPTH)) ||
                       (r_base_byte >= 8'(DEPTH)) || (w_span > (AW+2)'(DEPTH));
    assign w_last_word = ((r_words + (AW+1)'(1)) == r_count);

    byte_word_packer #(.W(N)) u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clr         (w_start_acc),
        .i_en          (w_pk_en),
        .i_byte        (byte_in),
        .o_word_next_c (w_word_next),
        .o_word_done_c (w_word_done),
        .o_word_ready  (w_word_ready)
    );

    assign byte_ready   = r_byte_ready;
    assign mem_we       = w_word_ready;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_stall    = r_cpu_stall;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

    // Frame FSM with registered status, write port and checksum
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_byte_ready <= 1'b0;
            r_cpu_stall  <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_words      <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_base_byte  <= '0;
            r_count      <= '0;
            r_csum       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (w_start_acc) begin
                        r_state      <= S_H_BASE;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_words      <= '0;
                        r_csum       <= '0;
                        r_byte_ready <= 1'b1;
                        r_cpu_stall  <= 1'b1;
                    end
                end
                S_H_BASE: begin
                    if (w_xfer) begin
                        r_base_byte <= byte_in;
                        r_state     <= S_H_CNT;
                    end
                end
                S_H_CNT: begin
                    if (w_xfer) begin
                        r_count <= byte_in[AW:0];
                        if (w_cnt_bad) begin
                            r_state      <= S_ERR;
                            r_error      <= 1'b1;
                            r_byte_ready <= 1'b0;
                            r_cpu_stall  <= 1'b0;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_xfer) begin
                        r_csum <= r_csum ^ byte_in;
                        if (w_word_done) begin
                            r_mem_addr  <= r_base_byte[AW-1:0] + r_words[AW-1:0];
                            r_mem_wdata <= w_word_next;
                            r_words     <= r_words + (AW+1)'(1);
                            if (w_last_word) begin
                                r_state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_byte_ready <= 1'b0;
                        r_cpu_stall  <= 1'b0;
                        if (byte_in == r_csum) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_byte_ready <= 1'b0;
                    r_cpu_stall  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed table, hand sequences, random frames.
module tb_instr_loader;

    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;
    logic          cpu_stall;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    instr_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_stall    (cpu_stall),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]        tx_q[$];
    logic [AW+N-1:0]   cap_q[$];

    // Capture every write the DUT performs
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) cap_q.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame rules at the level of the protocol description
    function automatic bit frame_bad(input int base, input int count);
        return (count == 0) || (count > 32) || (base >= 32) || (base + count > 32);
    endfunction

    function automatic logic [7:0] xor_payload();
        logic [7:0] x = 8'h00;
        foreach (tx_q[i]) x ^= tx_q[i];
        return x;
    endfunction

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (byte_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL byte_ready_timeout: got 0 expected 1 (byte %0h)", b);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] base, input logic [7:0] count,
                             input logic [7:0] csum, input bit gaps, input bit hdr_only);
        start_pulse();
        send_byte(base, gaps);
        send_byte(count, gaps);
        if (!hdr_only) begin
            foreach (tx_q[i]) send_byte(tx_q[i], gaps);
            send_byte(csum, gaps);
        end
        repeat (3) @(negedge clk);
    endtask

    // Compare status outputs and the captured writes against expectations
    task automatic check_result(input string name, input bit e_done, input bit e_err,
                                input int e_words, input int e_nwr, input int base);
        logic [AW+N-1:0] exp_wr;
        int m;
        chk({name, ".done"}, 64'(done), 64'(e_done));
        chk({name, ".error"}, 64'(error), 64'(e_err));
        chk({name, ".words"}, 64'(words_loaded), 64'(e_words));
        chk({name, ".stall"}, 64'(cpu_stall), 64'(0));
        chk({name, ".ready"}, 64'(byte_ready), 64'(0));
        chk({name, ".nwr"}, 64'(cap_q.size()), 64'(e_nwr));
        m = (cap_q.size() < e_nwr) ? cap_q.size() : e_nwr;
        for (int w = 0; w < m; w++) begin
            exp_wr = {AW'(base + w), tx_q[4*w], tx_q[4*w+1], tx_q[4*w+2], tx_q[4*w+3]};
            chk($sformatf("%s.wr%0d", name, w), 64'(cap_q[w]), 64'(exp_wr));
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] base;
        logic [7:0] count;
        bit         nominal;
        bit         good_csum;
        bit         gaps;
        bit         e_done;
        bit         e_err;
        int         e_words;
        int         e_nwr;
    } vec_t;

    vec_t vt[10];

    task automatic load_payload(input bit nominal, input int count, input int seed);
        tx_q.delete();
        if (nominal) tx_q = {8'h00, 8'h22, 8'h18, 8'h20, 8'h00, 8'h68, 8'h30, 8'h22};
        else for (int i = 0; i < count * 4; i++) tx_q.push_back(8'(i * 37 + seed));
    endtask

    initial begin
        logic [7:0] csum;
        logic [7:0] b, c;
        bit bad, gaps;

        vt[0] = '{"nominal",   8'h00, 8'h02, 1, 1, 0, 1, 0, 2, 2};
        vt[1] = '{"upper",     8'h1E, 8'h02, 1, 1, 0, 1, 0, 2, 2};
        vt[2] = '{"overflow",  8'h1F, 8'h02, 1, 1, 0, 0, 1, 0, 0};
        vt[3] = '{"zero_cnt",  8'h00, 8'h00, 1, 1, 0, 0, 1, 0, 0};
        vt[4] = '{"bad_csum",  8'h00, 8'h02, 1, 0, 0, 0, 1, 2, 2};
        vt[5] = '{"gaps",      8'h00, 8'h02, 1, 1, 1, 1, 0, 2, 2};
        vt[6] = '{"base_hi",   8'h20, 8'h01, 0, 1, 0, 0, 1, 0, 0};
        vt[7] = '{"cnt_33",    8'h00, 8'h21, 0, 1, 0, 0, 1, 0, 0};
        vt[8] = '{"full_mem",  8'h00, 8'h20, 0, 1, 0, 1, 0, 32, 32};
        vt[9] = '{"one_last",  8'h1F, 8'h01, 0, 1, 1, 1, 0, 1, 1};

        rst_n = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.ready", 64'(byte_ready), 64'(0));
        chk("rst.we", 64'(mem_we), 64'(0));
        chk("rst.addr", 64'(mem_addr), 64'(0));
        chk("rst.wdata", 64'(mem_wdata), 64'(0));
        chk("rst.stall", 64'(cpu_stall), 64'(0));
        chk("rst.status", 64'({done, error, words_loaded}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int k = 0; k < 10; k++) begin
            load_payload(vt[k].nominal, int'(vt[k].count), k);
            csum = xor_payload() ^ (vt[k].good_csum ? 8'h00 : 8'h01);
            cap_q.delete();
            run_frame(vt[k].base, vt[k].count, csum, vt[k].gaps, vt[k].e_nwr == 0);
            check_result(vt[k].name, vt[k].e_done, vt[k].e_err, vt[k].e_words,
                         vt[k].e_nwr, int'(vt[k].base));
        end

        // Stall during load; start while busy is ignored
        load_payload(1, 2, 0);
        cap_q.delete();
        start_pulse();
        chk("busy.stall", 64'(cpu_stall), 64'(1));
        chk("busy.ready", 64'(byte_ready), 64'(1));
        send_byte(8'h00, 0);
        start_pulse();
        send_byte(8'h02, 0);
        start_pulse();
        foreach (tx_q[i]) send_byte(tx_q[i], 0);
        chk("busy.mid_stall", 64'(cpu_stall), 64'(1));
        send_byte(8'h60, 0);
        repeat (3) @(negedge clk);
        check_result("busy", 1, 0, 2, 2, 0);
        chk("busy.addr_hold", 64'(mem_addr), 64'(1));
        chk("busy.data_hold", 64'(mem_wdata), 64'(32'h00683022));

        // Reset after the 5th payload byte aborts the frame
        cap_q.delete();
        start_pulse();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 5; i++) send_byte(tx_q[i], 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort.ready", 64'(byte_ready), 64'(0));
        chk("abort.addr", 64'(mem_addr), 64'(0));
        chk("abort.wdata", 64'(mem_wdata), 64'(0));
        chk("abort.stall", 64'(cpu_stall), 64'(0));
        chk("abort.status", 64'({done, error, words_loaded}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort.we", 64'(mem_we), 64'(0));
        chk("abort.nwr", 64'(cap_q.size()), 64'(1));
        if (cap_q.size() > 0) chk("abort.wr0", 64'(cap_q[0]), 64'({5'd0, 32'h00221820}));
        cap_q.delete();
        run_frame(8'h00, 8'h02, 8'h60, 0, 0);
        check_result("after_abort", 1, 0, 2, 2, 0);

        // Random frames against the protocol model
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(0, 40));
                c = 8'($urandom_range(0, 36));
            end else begin
                b = 8'($urandom_range(0, 31));
                c = 8'($urandom_range(1, 32 - int'(b)));
            end
            bad  = frame_bad(int'(b), int'(c));
            gaps = ($urandom_range(0, 1) == 1);
            tx_q.delete();
            if (!bad) for (int i = 0; i < int'(c) * 4; i++) tx_q.push_back(8'($urandom));
            csum = xor_payload();
            if ($urandom_range(0, 4) == 0) csum ^= 8'($urandom_range(1, 255));
            cap_q.delete();
            run_frame(b, c, csum, gaps, bad);
            if (bad) check_result($sformatf("rnd%0d", r), 0, 1, 0, 0, int'(b));
            else check_result($sformatf("rnd%0d", r), csum == xor_payload(),
                              csum != xor_payload(), int'(c), int'(c), int'(b));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global guard against a stalled run
    initial begin
        #3000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
